wishbone_controller: RTL and testbench
======================================

# wishbone_controller

Single-outstanding Wishbone pipelined initiator that turns a simple valid/ready request port into bus cycles on a `wishbone.controller` modport, and returns read data plus a completion status on a response port. It sits between a local sequencer (CPU shim, UART bridge, test driver) and the shared Wishbone bus of peripheral devices. It handles stall, ack/err/rty termination, bounded retry and a watchdog timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width; must match the `wishbone` interface.
- `DATA_WIDTH`, 32, data width; must match the interface. `SEL_WIDTH = DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255, maximum cycles from first `stb_o` to termination before abort. Must be ≥ 2.
- `MAX_RETRIES`, 3, number of re-issues allowed after `rty_i`.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when high with `req_valid`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_WIDTH: byte address.
- `req_data` input DATA_WIDTH: write data.
- `req_sel` input SEL_WIDTH: byte selects.
- `rsp_valid` output 1: response present; held until `rsp_ready`.
- `rsp_ready` input 1: response consumed.
- `rsp_data` output DATA_WIDTH: read data; 0 for writes and failures.
- `rsp_status` output `wb_status_t`: completion status.
- `wb` modport `wishbone.controller`: drives `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `sel_o`; samples `dat_i`, `ack_i`, `err_i`, `rty_i`, `stall_i`.

## Operation
- States: IDLE, REQUEST, WAIT, GAP, RESPOND.
- IDLE: `req_ready`=1. On `req_valid`, latch we/addr/data/sel, clear the retry and timeout counts, and go to REQUEST.
- REQUEST: `cyc_o`=`stb_o`=1 with latched fields on the bus. If `stall_i`=1, stay. If `stall_i`=0, the strobe is accepted and the state goes to WAIT.
- WAIT: `cyc_o`=1, `stb_o`=0. Terminations are sampled here only, with priority err > ack > rty when several are asserted together.
  - `err_i`: go to RESPOND with status ERR.
  - `ack_i`: go to RESPOND with status OK. For reads, capture `dat_i` into `rsp_data`.
  - `rty_i`: if retries < MAX_RETRIES, increment retries and go to GAP. Otherwise go to RESPOND with status RETRY_EXHAUSTED.
- GAP: `cyc_o`=0 for exactly one cycle, then REQUEST. The timeout count is reset on entry to REQUEST from GAP.
- Timeout: counts every cycle spent in REQUEST or WAIT. When it reaches TIMEOUT_CYCLES with no termination, go to RESPOND with status TIMEOUT. A termination arriving in that same cycle wins over the timeout.
- RESPOND: `cyc_o`=0, `rsp_valid`=1. Go to IDLE on `rsp_ready`.
- Any `ack_i`/`err_i`/`rty_i` seen while `cyc_o`=0 is ignored.
- Reset, including mid-cycle, gives immediate async return to IDLE. All bus outputs go to 0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=OK, and `req_ready`=0 while `rst_i` is high. No response is produced for an aborted transaction.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `wb` inputs or `req_valid` to any output.
- Zero-stall responder that acks one cycle after the strobe:
  - handshake at edge 0;
  - `stb_o` high in cycle 1;
  - `ack_i` sampled in cycle 2;
  - `rsp_valid` high in cycle 3.
- Best-case request-to-response latency is 3 cycles. Each stall cycle adds 1; each retry adds 2 plus the responder latency.
- `req_ready` is 1 only in IDLE, giving a throughput of at most one transaction per 4 cycles.
- Bus fields are stable from REQUEST entry until leaving WAIT.

## Structure
- Shared `types` package:
  - `wb_status_t` enum (`WB_OK`, `WB_ERR`, `WB_RETRY_EXHAUSTED`, `WB_TIMEOUT`);
  - `wb_ctrl_state_t` enum for the five states.
- Timeout logic sits in sub-module `wb_timeout_counter`: clear, enable and expired output, width `$clog2(TIMEOUT_CYCLES+1)`. The retry counter is inline.

## Test plan
- Write 0x000000A5, sel 0xF, to 0x10; responder with no stall, ack after 1 cycle. The bus shows we=1, adr=0x10, dat=0xA5 in cycle 1; `rsp_valid` in cycle 3 with status OK and `rsp_data`=0.
- Read from 0x20; responder stalls 3 cycles, then acks with 0xDEADBEEF. `stb_o` is held for 4 cycles and `rsp_data`=0xDEADBEEF with status OK.
- Responder answers `rty_i` 4 times. Four strobes are issued, each separated by one `cyc_o`=0 GAP cycle, and the final status is RETRY_EXHAUSTED. With 2 rty then ack, the status is OK.
- Responder never terminates, TIMEOUT_CYCLES=8. `cyc_o` drops after 8 cycles in REQUEST+WAIT and the status is TIMEOUT. A late `ack_i` afterwards is ignored.
- `err_i` and `ack_i` asserted together gives status ERR. `rsp_ready` held low for 5 cycles keeps `rsp_valid` and the data stable and `req_ready`=0.
- Assert `rst_i` mid-WAIT. All outputs are 0 immediately without waiting for a clock edge, no response is produced, and a new request after reset completes normally.

Source files
------------

// File: rtl/wishbone_controller_pkg.sv
// Shared types for the Wishbone initiator: completion status and controller FSM states.
package wishbone_controller_pkg;

    typedef enum logic [1:0] {
        WB_OK              = 2'd0,
        WB_ERR             = 2'd1,
        WB_RETRY_EXHAUSTED = 2'd2,
        WB_TIMEOUT         = 2'd3
    } wb_status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT,
        ST_GAP,
        ST_RESPOND
    } wb_ctrl_state_t;

endpackage

// File: rtl/wishbone_controller_if.sv
// Wishbone pipelined bus bundle; signal suffixes are from the initiator's point of view.
interface wishbone #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;
    logic                  err_i;
    logic                  rty_i;
    logic                  stall_i;

    modport controller (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i, rty_i, stall_i
    );

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i, rty_i, stall_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i, rty_i, stall_i
    );

endinterface

// File: rtl/wishbone_controller_timeout.sv
// Watchdog for one bus attempt: counts enabled cycles and flags the last allowed one.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // expired is raised during the TIMEOUT_CYCLES-th enabled cycle so the FSM leaves on that edge
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wishbone_controller.sv
// Single-outstanding Wishbone pipelined initiator bridging a valid/ready request port to the bus,
// with stall handling, err/ack/rty termination, bounded retry and a watchdog timeout.
module wishbone_controller
    import wishbone_controller_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 255,
    parameter int  MAX_RETRIES    = 3,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [SEL_WIDTH-1:0]  req_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output wb_status_t            rsp_status,
    wishbone.controller           wb
);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    wb_ctrl_state_t        state, state_next;
    wb_status_t            term_status;
    logic [DATA_WIDTH-1:0] term_data;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [RW-1:0]         retries;

    logic cyc, stb, on_bus, expired;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (!on_bus),
        .enable  (on_bus),
        .expired (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        term_status = WB_OK;
        term_data   = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_next = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (expired) begin
                    state_next  = ST_RESPOND;
                    term_status = WB_TIMEOUT;
                end else if (!wb.stall_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a termination in the expiring cycle still takes precedence over the timeout
                if (wb.err_i) begin
                    state_next  = ST_RESPOND;
                    term_status = WB_ERR;
                end else if (wb.ack_i) begin
                    state_next  = ST_RESPOND;
                    term_status = WB_OK;
                    term_data   = we_q ? '0 : wb.dat_i;
                end else if (wb.rty_i) begin
                    if (retries < RETRY_LIMIT) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next  = ST_RESPOND;
                        term_status = WB_RETRY_EXHAUSTED;
                    end
                end else if (expired) begin
                    state_next  = ST_RESPOND;
                    term_status = WB_TIMEOUT;
                end
            end
            ST_GAP: begin
                state_next = ST_REQUEST;
            end
            ST_RESPOND: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cyc       = (state == ST_REQUEST) || (state == ST_WAIT);
        stb       = (state == ST_REQUEST);
        on_bus    = cyc;
        rsp_valid = (state == ST_RESPOND);
        req_ready = (state == ST_IDLE) && !rst_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            retries    <= '0;
            rsp_data   <= '0;
            rsp_status <= WB_OK;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                adr_q   <= req_addr;
                dat_q   <= req_data;
                sel_q   <= req_sel;
                retries <= '0;
            end
            if (state == ST_WAIT && state_next == ST_GAP) begin
                retries <= retries + RW'(1);
            end
            if (state != ST_RESPOND && state_next == ST_RESPOND) begin
                rsp_data   <= term_data;
                rsp_status <= term_status;
            end
        end
    end

    assign wb.cyc_o = cyc;
    assign wb.stb_o = stb;
    assign wb.we_o  = we_q;
    assign wb.adr_o = adr_q;
    assign wb.dat_o = dat_q;
    assign wb.sel_o = sel_q;

endmodule

// File: tb/tb_wishbone_controller.sv
// Randomized self-checking bench: a scripted responder drives the bus and a transaction-level model predicts each response.
module tb_wishbone_controller;
    import wishbone_controller_pkg::*;

    localparam int TMO   = 8;
    localparam int MAX_R = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    wb_status_t  rsp_status;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // responder script per attempt: stall cycles, WAIT cycles until termination, {err,ack,rty} mask, read data
    int unsigned s_tab [8];
    int unsigned l_tab [8];
    logic [2:0]  t_tab [8];
    logic [31:0] d_tab [8];

    wishbone #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wishbone_controller #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (MAX_R)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .wb         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_attempt(input int idx, input int unsigned s, input int unsigned l,
                               input logic [2:0] m, input logic [31:0] d);
        s_tab[idx] = s;
        l_tab[idx] = l;
        t_tab[idx] = m;
        d_tab[idx] = d;
    endtask

    task automatic bus_quiet();
        bus.stall_i = 1'b0;
        bus.ack_i   = 1'b0;
        bus.err_i   = 1'b0;
        bus.rty_i   = 1'b0;
        bus.dat_i   = $urandom;
    endtask

    task automatic bus_junk();
        bus_quiet();
        {bus.err_i, bus.ack_i, bus.rty_i} = 3'($urandom_range(0, 7));
    endtask

    // Transaction-level prediction: each attempt lasts (stall+1)+wait cycles on the bus, capped by the watchdog.
    task automatic predict(input logic we, output wb_status_t st, output logic [31:0] d,
                           output int unsigned lat, output int unsigned stbc,
                           output int unsigned starts, output int unsigned gaps);
        int unsigned cycles = 0;
        st = WB_OK; d = '0; stbc = 0; starts = 0; gaps = 0;
        for (int a = 0; a <= MAX_R; a++) begin
            int unsigned sdur = s_tab[a] + 1;
            int unsigned tot  = (t_tab[a] == 3'b000) ? 1000 : sdur + l_tab[a];
            starts++;
            if (tot > TMO) begin
                cycles += TMO;
                stbc   += (sdur < TMO) ? sdur : TMO;
                st = WB_TIMEOUT;
                break;
            end
            cycles += tot;
            stbc   += sdur;
            if (t_tab[a][2]) begin st = WB_ERR; break; end
            if (t_tab[a][1]) begin st = WB_OK; d = we ? 32'h0 : d_tab[a]; break; end
            if (a == MAX_R) begin st = WB_RETRY_EXHAUSTED; break; end
            cycles += 1;
            gaps++;
        end
        lat = cycles + 1;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, input int unsigned hold);
        wb_status_t  es, st0;
        logic [31:0] ed, d0;
        int unsigned elat, estb, estarts, egaps;
        int unsigned a = 0, stalls = 0, waits = 0, n = 0;
        int unsigned stbc = 0, starts = 0, gaps = 0, fld_bad = 0, hold_bad = 0;
        logic prev_stb = 1'b0;
        logic done = 1'b0;

        predict(we, es, ed, elat, estb, estarts, egaps);
        @(negedge clk);
        bus_quiet();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_sel = sel;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
            req_we = $urandom_range(0, 1); req_addr = $urandom; req_data = $urandom; req_sel = 4'($urandom);
            bus_quiet();
            if (rsp_valid) begin
                done = 1'b1;
                bus_junk();
            end else if (bus.stb_o) begin
                if (!prev_stb) starts++;
                stbc++;
                if (bus.adr_o !== addr || bus.we_o !== we || bus.dat_o !== data || bus.sel_o !== sel || !bus.cyc_o)
                    fld_bad++;
                if (stalls < s_tab[a]) begin
                    bus.stall_i = 1'b1;
                    stalls++;
                end else begin
                    waits = 0;
                end
            end else if (bus.cyc_o) begin
                if (bus.adr_o !== addr || bus.we_o !== we || bus.dat_o !== data || bus.sel_o !== sel)
                    fld_bad++;
                waits++;
                if (waits == l_tab[a]) begin
                    {bus.err_i, bus.ack_i, bus.rty_i} = t_tab[a];
                    bus.dat_i = d_tab[a];
                    if (t_tab[a] == 3'b001 && a < 7) begin
                        a++;
                        stalls = 0;
                    end
                end
            end else begin
                gaps++;
                bus_junk();
            end
            prev_stb = bus.stb_o;
        end

        check("rsp_within_bound", rsp_valid, 1);
        check("latency", n, elat);
        check("status", rsp_status, es);
        check("rsp_data", rsp_data, ed);
        check("stb_cycles", stbc, estb);
        check("strobe_starts", starts, estarts);
        check("gap_cycles", gaps, egaps);
        check("bus_fields", fld_bad, 0);

        d0 = rsp_data;
        st0 = rsp_status;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            bus_junk();
            if (!rsp_valid || rsp_data !== d0 || rsp_status !== st0 || req_ready || bus.cyc_o)
                hold_bad++;
        end
        check("hold_stable", hold_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        bus_junk();
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
        @(negedge clk);
        bus_quiet();
    endtask

    initial begin
        int unsigned noresp_bad;
        bus_quiet();
        #1 rst_i = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_cyc", bus.cyc_o, 0);
        check("rst_stb", bus.stb_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, WB_OK);
        check("rst_bus_fields", {bus.we_o, bus.adr_o, bus.dat_o, bus.sel_o}, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        set_attempt(0, 0, 1, 3'b010, 32'h0);
        run_txn(1'b1, 32'h10, 32'h0000_00A5, 4'hF, 0);

        set_attempt(0, 3, 1, 3'b010, 32'hDEAD_BEEF);
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1);

        for (int i = 0; i < 4; i++) set_attempt(i, 0, 1, 3'b001, 32'h0);
        run_txn(1'b0, 32'h30, 32'h0, 4'hF, 0);

        set_attempt(0, 0, 1, 3'b001, 32'h0);
        set_attempt(1, 1, 2, 3'b001, 32'h0);
        set_attempt(2, 0, 1, 3'b010, 32'h1234_5678);
        run_txn(1'b0, 32'h34, 32'h0, 4'h3, 0);

        set_attempt(0, 0, 1, 3'b000, 32'h0);
        run_txn(1'b0, 32'h38, 32'h0, 4'hF, 3);

        set_attempt(0, 0, 2, 3'b110, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h3C, 32'h0, 4'hF, 5);

        // abort mid-WAIT with an asynchronous reset between clock edges
        set_attempt(0, 0, 1, 3'b000, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_data = 32'h5A5A_5A5A; req_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_wait_cyc", bus.cyc_o, 1);
        check("mid_wait_stb", bus.stb_o, 0);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_cyc", bus.cyc_o, 0);
        check("async_rst_fields", {bus.we_o, bus.adr_o, bus.dat_o, bus.sel_o}, 0);
        check("async_rst_req_ready", req_ready, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_i = 1'b0;
        noresp_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || bus.cyc_o) noresp_bad++;
        end
        check("no_rsp_after_abort", noresp_bad, 0);

        set_attempt(0, 1, 1, 3'b010, 32'h0BAD_F00D);
        run_txn(1'b0, 32'h44, 32'h0, 4'hF, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned r = $urandom_range(0, 19);
                logic [2:0] m;
                if (r == 0)       m = 3'b000;
                else if (r <= 8)  m = 3'b010;
                else if (r <= 10) m = 3'b100;
                else if (r <= 16) m = 3'b001;
                else if (r == 17) m = 3'b110;
                else if (r == 18) m = 3'b011;
                else              m = 3'b101;
                set_attempt(i, $urandom_range(0, 3), $urandom_range(1, 5), m, $urandom);
            end
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
